// File: rtl/rsa_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rsa_run_ctrl
// Description : Run sequencer for the RSA pipeline CPU top. After a go request
//               it holds the CPU in reset for RST_CYCLES cycles, then waits
//               START_DELAY cycles, then asserts start. It counts RUN cycles
//               until EndFlag or a timeout, and captures ReadData / FlagZero
//               when EndFlag arrives.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               go, abort         - run request / cancel
//               EndFlag, FlagZero,
//               ReadData          - CPU status and data inputs
//               cpu_reset,
//               cpu_start         - CPU control outputs
//               busy, done,
//               timeout           - run status
//               cycle_count       - RUN cycles of the current/last run
//               result, zero_flag - values captured at EndFlag
//               run_count         - completed runs, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module rsa_run_ctrl #(
    parameter int DATA_W         = 32,
    parameter int CNT_W          = 32,
    parameter int RST_CYCLES     = 2,
    parameter int START_DELAY    = 1,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int RUNS_W         = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              abort,
    input  logic              EndFlag,
    input  logic              FlagZero,
    input  logic [DATA_W-1:0] ReadData,
    output logic              cpu_reset,
    output logic              cpu_start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [DATA_W-1:0] result,
    output logic              zero_flag,
    output logic [RUNS_W-1:0] run_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_DELAY   = 3'd2,
        S_RUN     = 3'd3,
        S_DONE    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    // The DELAY terminal value is guarded so START_DELAY=0 does not underflow;
    // DELAY is never entered in that configuration.
    localparam int               c_sd_last_int = (START_DELAY > 0) ? START_DELAY - 1 : 0;
    localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_sd_last     = CNT_W'(c_sd_last_int);
    localparam logic [CNT_W-1:0] c_to_last     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_to_full     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);
    localparam logic [RUNS_W-1:0] c_runs_one   = RUNS_W'(1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    phase_q, phase_d;          // cycles spent in RST / DELAY
    logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                zero_flag_q, zero_flag_d;
    logic [RUNS_W-1:0]   run_count_q, run_count_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                cpu_start_q, cpu_start_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    // Next-state and datapath logic
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cycle_count_d = cycle_count_q;
        result_d      = result_q;
        zero_flag_d   = zero_flag_q;
        run_count_d   = run_count_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d       = S_RST;
                    phase_d       = '0;
                    cycle_count_d = '0;
                end
            end

            S_RST: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_q == c_rst_last) begin
                    phase_d = '0;
                    state_d = (START_DELAY == 0) ? S_RUN : S_DELAY;
                end else begin
                    phase_d = phase_q + c_cnt_one;
                end
            end

            S_DELAY: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (phase_q == c_sd_last) begin
                    phase_d = '0;
                    state_d = S_RUN;
                end else begin
                    phase_d = phase_q + c_cnt_one;
                end
            end

            S_RUN: begin
                // Priority: abort, then EndFlag, then timeout.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (EndFlag) begin
                    state_d     = S_DONE;
                    result_d    = ReadData;
                    zero_flag_d = FlagZero;
                    if (run_count_q != '1) begin
                        run_count_d = run_count_q + c_runs_one;
                    end
                end else if (cycle_count_q == c_to_last) begin
                    state_d       = S_TIMEOUT;
                    cycle_count_d = c_to_full;
                end else begin
                    cycle_count_d = cycle_count_q + c_cnt_one;
                end
            end

            S_DONE, S_TIMEOUT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (go) begin
                    state_d       = S_RST;
                    phase_d       = '0;
                    cycle_count_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered decodes of the next state, so they line up
        // with the state register without any input-to-output path.
        cpu_reset_d = (state_d == S_IDLE) || (state_d == S_RST);
        cpu_start_d = (state_d == S_RUN);
        busy_d      = (state_d == S_RST) || (state_d == S_DELAY) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
        timeout_d   = (state_d == S_TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            cycle_count_q <= '0;
            result_q      <= '0;
            zero_flag_q   <= 1'b0;
            run_count_q   <= '0;
            cpu_reset_q   <= 1'b1;
            cpu_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cycle_count_q <= cycle_count_d;
            result_q      <= result_d;
            zero_flag_q   <= zero_flag_d;
            run_count_q   <= run_count_d;
            cpu_reset_q   <= cpu_reset_d;
            cpu_start_q   <= cpu_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign cpu_start   = cpu_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;
    assign result      = result_q;
    assign zero_flag   = zero_flag_q;
    assign run_count   = run_count_q;

endmodule
`default_nettype wire

// File: tb/tb_rsa_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_run_ctrl
// Description : Directed self-checking bench for rsa_run_ctrl. Instance dut_a
//               uses RST_CYCLES=2, START_DELAY=1, TIMEOUT_CYCLES=10; instance
//               dut_b uses RST_CYCLES=1, START_DELAY=0 for latency and
//               back-to-back saturation checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_run_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a stimulus / observation
    logic        reset = 1'b1, go = 1'b0, abort = 1'b0;
    logic        end_flag = 1'b0, flag_zero = 1'b0;
    logic [31:0] read_data = 32'h0;
    logic        a_cpu_reset, a_cpu_start, a_busy, a_done, a_timeout, a_zero_flag;
    logic [31:0] a_cycle_count, a_result;
    logic [7:0]  a_run_count;

    // dut_b stimulus / observation
    logic        b_reset = 1'b1, b_go = 1'b0, b_abort = 1'b0, b_end = 1'b0;
    logic        b_flag_zero = 1'b0;
    logic [31:0] b_read_data = 32'h0000_0055;
    logic        b_cpu_reset, b_cpu_start, b_busy, b_done, b_timeout, b_zero_flag;
    logic [31:0] b_cycle_count, b_result;
    logic [7:0]  b_run_count;

    int total  = 0;
    int passed = 0;

    rsa_run_ctrl #(
        .DATA_W(32), .CNT_W(32), .RST_CYCLES(2), .START_DELAY(1),
        .TIMEOUT_CYCLES(10), .RUNS_W(8)
    ) dut_a (
        .clk(clk), .reset(reset), .go(go), .abort(abort),
        .EndFlag(end_flag), .FlagZero(flag_zero), .ReadData(read_data),
        .cpu_reset(a_cpu_reset), .cpu_start(a_cpu_start), .busy(a_busy),
        .done(a_done), .timeout(a_timeout), .cycle_count(a_cycle_count),
        .result(a_result), .zero_flag(a_zero_flag), .run_count(a_run_count)
    );

    rsa_run_ctrl #(
        .DATA_W(32), .CNT_W(32), .RST_CYCLES(1), .START_DELAY(0),
        .TIMEOUT_CYCLES(10), .RUNS_W(8)
    ) dut_b (
        .clk(clk), .reset(b_reset), .go(b_go), .abort(b_abort),
        .EndFlag(b_end), .FlagZero(b_flag_zero), .ReadData(b_read_data),
        .cpu_reset(b_cpu_reset), .cpu_start(b_cpu_start), .busy(b_busy),
        .done(b_done), .timeout(b_timeout), .cycle_count(b_cycle_count),
        .result(b_result), .zero_flag(b_zero_flag), .run_count(b_run_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse go on dut_a and advance to the first RUN cycle (2 RST + 1 DELAY).
    task automatic start_run_a();
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; b_reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0; b_reset = 1'b0;
        total++; if (a_cpu_reset !== 1'b1) $display("FAIL reset_cpu_reset: got %b want 1", a_cpu_reset); else passed++;
        total++; if ({a_cpu_start, a_busy, a_done, a_timeout, a_zero_flag} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {a_cpu_start, a_busy, a_done, a_timeout, a_zero_flag}); else passed++;
        total++; if (a_cycle_count !== 32'd0) $display("FAIL reset_cycle_count: got %0d want 0", a_cycle_count); else passed++;
        total++; if (a_result !== 32'd0) $display("FAIL reset_result: got %h want 0", a_result); else passed++;
        total++; if (a_run_count !== 8'd0) $display("FAIL reset_run_count: got %0d want 0", a_run_count); else passed++;
        tick();
        total++; if (a_cpu_reset !== 1'b1 || a_busy !== 1'b0) $display("FAIL idle_hold: got cpu_reset=%b busy=%b want 1/0", a_cpu_reset, a_busy); else passed++;
    endtask

    task automatic test_basic_run();
        read_data = 32'hDEAD_BEEF; flag_zero = 1'b1;
        go = 1'b1;
        tick();
        go = 1'b0;
        total++; if ({a_cpu_reset, a_cpu_start, a_busy} !== 3'b101) $display("FAIL basic_rst1: got rst/start/busy=%b want 101", {a_cpu_reset, a_cpu_start, a_busy}); else passed++;
        tick();
        total++; if ({a_cpu_reset, a_cpu_start} !== 2'b10) $display("FAIL basic_rst2: got rst/start=%b want 10", {a_cpu_reset, a_cpu_start}); else passed++;
        tick();
        total++; if ({a_cpu_reset, a_cpu_start, a_busy} !== 3'b001) $display("FAIL basic_delay: got rst/start/busy=%b want 001", {a_cpu_reset, a_cpu_start, a_busy}); else passed++;
        tick();
        total++; if (a_cpu_start !== 1'b1 || a_cycle_count !== 32'd0) $display("FAIL basic_run_entry: got start=%b count=%0d want 1/0", a_cpu_start, a_cycle_count); else passed++;
        repeat (7) tick();
        total++; if (a_cycle_count !== 32'd7 || a_cpu_start !== 1'b1) $display("FAIL basic_run_count: got count=%0d start=%b want 7/1", a_cycle_count, a_cpu_start); else passed++;
        end_flag = 1'b1;
        tick();
        end_flag = 1'b0;
        read_data = 32'h0BAD_0BAD; flag_zero = 1'b0;
        total++; if ({a_done, a_timeout, a_busy, a_cpu_start, a_cpu_reset} !== 5'b10000) $display("FAIL basic_done_flags: got %b want 10000", {a_done, a_timeout, a_busy, a_cpu_start, a_cpu_reset}); else passed++;
        total++; if (a_cycle_count !== 32'd7) $display("FAIL basic_done_count: got %0d want 7", a_cycle_count); else passed++;
        total++; if (a_result !== 32'hDEAD_BEEF || a_zero_flag !== 1'b1) $display("FAIL basic_capture: got %h/%b want deadbeef/1", a_result, a_zero_flag); else passed++;
        total++; if (a_run_count !== 8'd1) $display("FAIL basic_run_count_inc: got %0d want 1", a_run_count); else passed++;
        tick();
        total++; if (a_done !== 1'b1 || a_result !== 32'hDEAD_BEEF) $display("FAIL basic_done_hold: got done=%b result=%h want 1/deadbeef", a_done, a_result); else passed++;
    endtask

    task automatic test_timeout();
        go = 1'b1;
        tick();
        go = 1'b0;
        total++; if (a_done !== 1'b0 || a_cycle_count !== 32'd0) $display("FAIL to_rst_clear: got done=%b count=%0d want 0/0", a_done, a_cycle_count); else passed++;
        repeat (3) tick();
        repeat (9) tick();
        total++; if (a_cycle_count !== 32'd9 || a_timeout !== 1'b0 || a_cpu_start !== 1'b1) $display("FAIL to_pre: got count=%0d timeout=%b start=%b want 9/0/1", a_cycle_count, a_timeout, a_cpu_start); else passed++;
        tick();
        total++; if (a_timeout !== 1'b1 || a_done !== 1'b0 || a_cpu_start !== 1'b0 || a_busy !== 1'b0) $display("FAIL to_flags: got timeout/done/start/busy=%b%b%b%b want 1000", a_timeout, a_done, a_cpu_start, a_busy); else passed++;
        total++; if (a_cycle_count !== 32'd10) $display("FAIL to_count: got %0d want 10", a_cycle_count); else passed++;
        total++; if (a_run_count !== 8'd1 || a_result !== 32'hDEAD_BEEF || a_zero_flag !== 1'b1) $display("FAIL to_keep: got runs=%0d result=%h zf=%b want 1/deadbeef/1", a_run_count, a_result, a_zero_flag); else passed++;
        // EndFlag in TIMEOUT must be ignored
        end_flag = 1'b1;
        tick();
        end_flag = 1'b0;
        total++; if (a_timeout !== 1'b1 || a_run_count !== 8'd1) $display("FAIL to_endflag_ignored: got timeout=%b runs=%0d want 1/1", a_timeout, a_run_count); else passed++;
    endtask

    task automatic test_endflag_on_timeout();
        go = 1'b1;
        tick();
        go = 1'b0;
        total++; if (a_timeout !== 1'b0) $display("FAIL eot_rst_clear: got timeout=%b want 0", a_timeout); else passed++;
        repeat (3) tick();
        repeat (9) tick();
        read_data = 32'hCAFE_0001; flag_zero = 1'b0; end_flag = 1'b1;
        tick();
        end_flag = 1'b0;
        total++; if (a_done !== 1'b1 || a_timeout !== 1'b0) $display("FAIL eot_state: got done=%b timeout=%b want 1/0", a_done, a_timeout); else passed++;
        total++; if (a_cycle_count !== 32'd9) $display("FAIL eot_count: got %0d want 9", a_cycle_count); else passed++;
        total++; if (a_result !== 32'hCAFE_0001 || a_zero_flag !== 1'b0 || a_run_count !== 8'd2) $display("FAIL eot_capture: got %h/%b/%0d want cafe0001/0/2", a_result, a_zero_flag, a_run_count); else passed++;
    endtask

    task automatic test_abort();
        start_run_a();
        repeat (3) tick();
        // abort together with EndFlag: abort must win
        abort = 1'b1; end_flag = 1'b1; read_data = 32'h1111_1111;
        tick();
        abort = 1'b0; end_flag = 1'b0;
        total++; if ({a_cpu_reset, a_busy, a_done, a_cpu_start} !== 4'b1000) $display("FAIL abort_flags: got rst/busy/done/start=%b want 1000", {a_cpu_reset, a_busy, a_done, a_cpu_start}); else passed++;
        total++; if (a_cycle_count !== 32'd3) $display("FAIL abort_count: got %0d want 3", a_cycle_count); else passed++;
        total++; if (a_result !== 32'hCAFE_0001 || a_run_count !== 8'd2) $display("FAIL abort_keep: got %h/%0d want cafe0001/2", a_result, a_run_count); else passed++;
        // next go runs normally
        start_run_a();
        repeat (2) tick();
        read_data = 32'h0000_0042; flag_zero = 1'b1; end_flag = 1'b1;
        tick();
        end_flag = 1'b0;
        total++; if (a_done !== 1'b1 || a_cycle_count !== 32'd2 || a_result !== 32'h42 || a_run_count !== 8'd3) $display("FAIL abort_rerun: got done=%b count=%0d result=%h runs=%0d want 1/2/42/3", a_done, a_cycle_count, a_result, a_run_count); else passed++;
        // abort from DONE
        abort = 1'b1; go = 1'b1;
        tick();
        abort = 1'b0; go = 1'b0;
        total++; if ({a_done, a_busy, a_cpu_reset} !== 3'b001 || a_run_count !== 8'd3) $display("FAIL abort_from_done: got done/busy/rst=%b runs=%0d want 001/3", {a_done, a_busy, a_cpu_reset}, a_run_count); else passed++;
    endtask

    task automatic test_reset_mid_run();
        start_run_a();
        repeat (2) tick();
        reset = 1'b1; end_flag = 1'b1;
        tick();
        total++; if ({a_cpu_reset, a_cpu_start, a_busy, a_done, a_timeout, a_zero_flag} !== 6'b100000) $display("FAIL midrst_flags: got %b want 100000", {a_cpu_reset, a_cpu_start, a_busy, a_done, a_timeout, a_zero_flag}); else passed++;
        total++; if (a_cycle_count !== 32'd0 || a_result !== 32'd0 || a_run_count !== 8'd0) $display("FAIL midrst_regs: got count=%0d result=%h runs=%0d want 0/0/0", a_cycle_count, a_result, a_run_count); else passed++;
        tick();
        reset = 1'b0;
        tick();
        end_flag = 1'b0;
        total++; if (a_done !== 1'b0 || a_run_count !== 8'd0 || a_cpu_reset !== 1'b1) $display("FAIL midrst_endflag_ignored: got done=%b runs=%0d rst=%b want 0/0/1", a_done, a_run_count, a_cpu_reset); else passed++;
    endtask

    task automatic test_back_to_back();
        int budget;
        b_go = 1'b1;
        tick();
        total++; if ({b_cpu_reset, b_cpu_start, b_busy} !== 3'b101) $display("FAIL b2b_rst: got rst/start/busy=%b want 101", {b_cpu_reset, b_cpu_start, b_busy}); else passed++;
        tick();
        total++; if ({b_cpu_reset, b_cpu_start} !== 2'b01) $display("FAIL b2b_start_latency: got rst/start=%b want 01", {b_cpu_reset, b_cpu_start}); else passed++;
        b_end = 1'b1;
        tick();
        total++; if (b_done !== 1'b1 || b_run_count !== 8'd1 || b_result !== 32'h55) $display("FAIL b2b_first_done: got done=%b runs=%0d result=%h want 1/1/55", b_done, b_run_count, b_result); else passed++;
        tick();
        total++; if (b_done !== 1'b0 || b_busy !== 1'b1) $display("FAIL b2b_done_one_cycle: got done=%b busy=%b want 0/1", b_done, b_busy); else passed++;
        repeat (2) tick();
        total++; if (b_done !== 1'b1 || b_run_count !== 8'd2) $display("FAIL b2b_second_done: got done=%b runs=%0d want 1/2", b_done, b_run_count); else passed++;
        // 3 cycles per run; bounded wait for 254 runs
        budget = 0;
        while (b_run_count !== 8'd254 && budget < 1000) begin
            tick();
            budget++;
        end
        total++; if (b_run_count !== 8'd254) $display("FAIL b2b_reach_254: got %0d want 254", b_run_count); else passed++;
        repeat (3) tick();
        total++; if (b_run_count !== 8'd255) $display("FAIL b2b_reach_255: got %0d want 255", b_run_count); else passed++;
        repeat (9) tick();
        total++; if (b_run_count !== 8'd255) $display("FAIL b2b_saturate: got %0d want 255", b_run_count); else passed++;
        b_go = 1'b0; b_end = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_timeout();
        test_endflag_on_timeout();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
